// File: rtl/cpu_core.sv
// Accumulator CPU core: multi-cycle FETCH/DECODE/EXEC/MEM sequencer on a
// request/acknowledge memory bus with an output register and a halt state.
module cpu_core #(
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = WIDTH - 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  output logic              halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_e;
  typedef enum logic [1:0] {ALU_NONE, ALU_ADD, ALU_SUB} alu_e;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [WIDTH:0]    ALU_ONE = 1;

  state_e              state_q;
  alu_e                alu_q;
  logic [WIDTH-1:0]    a_q, b_q, ir_q, out_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                c_q, z_q, out_valid_q, fetch_busy_q;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic                fetch_req, mem_done;
  logic [WIDTH:0]      alu_full;
  logic [WIDTH-1:0]    a_view;

  assign opcode  = ir_q[WIDTH-1:WIDTH-4];
  assign operand = ir_q[ADDR_W-1:0];

  // ADD/SUB latch B on the completing edge and write A/C/Z back on the next
  // edge (first FETCH cycle); a_view exposes the post-ALU value of A early so
  // the bus never sees A change while a request is held.
  always_comb begin
    alu_full = {1'b0, a_q} + {1'b0, b_q};
    if (alu_q == ALU_SUB) alu_full = {1'b0, a_q} + {1'b0, ~b_q} + ALU_ONE;
  end
  assign a_view = (alu_q == ALU_NONE) ? a_q : alu_full[WIDTH-1:0];

  // Once a fetch is requested it is held to completion even if run drops.
  assign fetch_req = (state_q == S_FETCH) && (run || fetch_busy_q);
  assign mem_req   = reset && (fetch_req || (state_q == S_MEM));
  assign mem_we    = mem_req && (state_q == S_MEM) && (opcode == OP_STA);
  assign mem_addr  = (state_q == S_MEM) ? operand : pc_q;
  assign mem_wdata = a_view;
  assign mem_done  = mem_req && mem_ack;

  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      alu_q        <= ALU_NONE;
      a_q          <= '0;
      b_q          <= '0;
      ir_q         <= '0;
      out_q        <= '0;
      pc_q         <= '0;
      c_q          <= 1'b0;
      z_q          <= 1'b0;
      out_valid_q  <= 1'b0;
      fetch_busy_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (alu_q != ALU_NONE) begin
        a_q   <= alu_full[WIDTH-1:0];
        c_q   <= alu_full[WIDTH];
        z_q   <= (alu_full[WIDTH-1:0] == '0);
        alu_q <= ALU_NONE;
      end
      case (state_q)
        S_FETCH: begin
          if (mem_done) begin
            ir_q         <= mem_rdata;
            pc_q         <= pc_q + PC_ONE;
            fetch_busy_q <= 1'b0;
            state_q      <= S_DECODE;
          end else if (fetch_req) begin
            fetch_busy_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB || opcode == OP_STA)
            state_q <= S_MEM;
          else
            state_q <= S_EXEC;
        end
        S_MEM: begin
          if (mem_done) begin
            case (opcode)
              OP_LDA:  a_q <= mem_rdata;
              OP_ADD:  begin b_q <= mem_rdata; alu_q <= ALU_ADD; end
              OP_SUB:  begin b_q <= mem_rdata; alu_q <= ALU_SUB; end
              default: ;
            endcase
            state_q <= S_FETCH;
          end
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (opcode)
            OP_LDI:  a_q <= {4'b0000, operand};
            OP_JMP:  pc_q <= operand;
            OP_JC:   if (c_q) pc_q <= operand;
            OP_JZ:   if (z_q) pc_q <= operand;
            OP_OUT:  begin out_q <= a_q; out_valid_q <= 1'b1; end
            OP_HLT:  state_q <= S_HALT;
            default: ;
          endcase
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
